// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and types for the falling-note game
package game_pkg;

  localparam int NUM_LANES   = 5;
  localparam int SCREEN_ROWS = 480;

  typedef logic [7:0] chart_entry_t;

  localparam chart_entry_t CHART_END = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // 12-bit RGB lane colours, left to right
  localparam logic [11:0] LANE_GREEN  = 12'h0F0;
  localparam logic [11:0] LANE_RED    = 12'hF00;
  localparam logic [11:0] LANE_YELLOW = 12'hFF0;
  localparam logic [11:0] LANE_BLUE   = 12'h00F;
  localparam logic [11:0] LANE_ORANGE = 12'hF80;

endpackage

// File: rtl/chart_rom.sv
// rtl/chart_rom.sv - synchronous chart ROM, one-cycle read latency
module chart_rom
  import game_pkg::*;
#(
  parameter int                       CHART_DEPTH = 256,
  // Entry i occupies bits [8*i +: 8]; unprogrammed entries read as END
  parameter logic [CHART_DEPTH*8-1:0] CHART_INIT  = '1,
  localparam int                      AW          = $clog2(CHART_DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output chart_entry_t  data_o
);

  chart_entry_t data_q;

  // Registered read of the addressed chart entry
  always_ff @(posedge clk) begin
    data_q <= CHART_INIT[{addr_i, 3'b000} +: 8];
  end

  assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - chart stepper issuing per-lane spawn pulses; NOTE_SEQUENCER_LOOP_EN selects endless looping
module note_sequencer #(
  parameter int                       NUM_LANES       = 5,
  parameter int                       CHART_DEPTH     = 256,
  parameter int                       FRAMES_PER_STEP = 12,
  parameter int                       FRAME_ROW       = 480,
  parameter logic [CHART_DEPTH*8-1:0] CHART_INIT      = '1,
  localparam int                      AW              = $clog2(CHART_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           col,
  input  logic [9:0]           row,
  input  logic                 valid,
  input  logic                 start,
  input  logic                 pause,
  output logic [NUM_LANES-1:0] spawn,
  output logic [AW-1:0]        step_idx,
  output logic                 busy,
  output logic                 done
);

  import game_pkg::*;

  localparam int           FCW      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCW-1:0] CNT_LAST = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [AW-1:0]  IDX_LAST = AW'(CHART_DEPTH - 1);

  seq_state_t             state_q, state_d;
  logic [AW-1:0]          step_idx_q, step_idx_d;
  logic [FCW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [NUM_LANES-1:0]   spawn_q, spawn_d;
  logic                   frame_tick_q;
  chart_entry_t           rom_data;

  // Raster position bits are used only for the strobe compare; valid is informational
  logic unused_inputs;
  assign unused_inputs = ^{valid, rom_data[7:NUM_LANES]};

  chart_rom #(
    .CHART_DEPTH (CHART_DEPTH),
    .CHART_INIT  (CHART_INIT)
  ) u_chart_rom (
    .clk    (clk),
    .addr_i (step_idx_q),
    .data_o (rom_data)
  );

  // Once-per-frame strobe, one cycle after the first pixel of the first blanking line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= (row == 10'(FRAME_ROW)) && (col == 10'd0);
    end
  end

  // Sequencer state, chart pointer, frame counter and registered spawn pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_idx_q  <= '0;
      frame_cnt_q <= '0;
      spawn_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      frame_cnt_q <= frame_cnt_d;
      spawn_q     <= spawn_d;
    end
  end

  // Next-state: start (re)launches playback; a counted frame tick may trigger a step
  always_comb begin
    state_d     = state_q;
    step_idx_d  = step_idx_q;
    frame_cnt_d = frame_cnt_q;
    spawn_d     = '0;
    case (state_q)
      IDLE, DONE: begin
        // A tick coinciding with start is deliberately not counted
        if (start) begin
          state_d     = RUN;
          step_idx_d  = '0;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        if (frame_tick_q && !pause) begin
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            if (rom_data == CHART_END) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
              step_idx_d = '0;
`else
              state_d = DONE;
`endif
            end else begin
              spawn_d = rom_data[NUM_LANES-1:0];
              if (step_idx_q == IDX_LAST) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                step_idx_d = '0;
`else
                // Pointer parks on the last entry rather than wrapping
                state_d = DONE;
`endif
              end else begin
                step_idx_d = step_idx_q + 1'b1;
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spawn    = spawn_q;
  assign step_idx = step_idx_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

  localparam int COLS = 16;
  localparam int ROWS = 20;
  localparam int FR   = 16;

  logic       clk = 1'b0;
  logic [9:0] col = '0;
  logic [9:0] row = '0;
  logic       vld;

  logic       rst_n_a = 1'b0, start_a = 1'b0, pause_a = 1'b0;
  logic       rst_n_c = 1'b0, start_c = 1'b0, pause_c = 1'b0;
  logic       rst_n_d = 1'b0, start_d = 1'b0, pause_d = 1'b0;
  logic [4:0] spawn_a, spawn_c, spawn_d;
  logic [7:0] idx_a, idx_d;
  logic [1:0] idx_c;
  logic       busy_a, done_a, busy_c, done_c, busy_d, done_d;

  int errors = 0;
  int checks = 0;
  int pulses_a = 0;
  int snap;

  always #5 clk = ~clk;

  assign vld = (col < 10'd12) && (row < 10'd16);

  note_sequencer #(
    .NUM_LANES(5), .CHART_DEPTH(256), .FRAMES_PER_STEP(2), .FRAME_ROW(FR),
    .CHART_INIT({{253{8'hFF}}, 8'hFF, 8'h03, 8'h10})
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .col(col), .row(row), .valid(vld),
    .start(start_a), .pause(pause_a), .spawn(spawn_a), .step_idx(idx_a),
    .busy(busy_a), .done(done_a)
  );

  note_sequencer #(
    .NUM_LANES(5), .CHART_DEPTH(4), .FRAMES_PER_STEP(1), .FRAME_ROW(FR),
    .CHART_INIT({8'h08, 8'h04, 8'h02, 8'h01})
  ) dut_c (
    .clk(clk), .rst_n(rst_n_c), .col(col), .row(row), .valid(vld),
    .start(start_c), .pause(pause_c), .spawn(spawn_c), .step_idx(idx_c),
    .busy(busy_c), .done(done_c)
  );

  note_sequencer #(
    .NUM_LANES(5), .CHART_DEPTH(256), .FRAMES_PER_STEP(1), .FRAME_ROW(FR),
    .CHART_INIT({{253{8'hFF}}, 8'hFF, 8'h04, 8'h00})
  ) dut_d (
    .clk(clk), .rst_n(rst_n_d), .col(col), .row(row), .valid(vld),
    .start(start_d), .pause(pause_d), .spawn(spawn_d), .step_idx(idx_d),
    .busy(busy_d), .done(done_d)
  );

  // Count every cycle on which lane A drives a nonzero spawn
  always @(negedge clk) begin
    if (spawn_a != 5'd0) pulses_a <= pulses_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (col == 10'(COLS - 1)) begin
      col = '0;
      row = (row == 10'(ROWS - 1)) ? 10'd0 : row + 10'd1;
    end else begin
      col = col + 10'd1;
    end
  endtask

  task automatic run_to_strobe();
    for (int i = 0; i < COLS * ROWS + 4; i++) begin
      if (row == 10'(FR) && col == 10'd0) return;
      tick_clk();
    end
    chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  // Ends where a spawn caused by this frame's tick is visible
  task automatic frame();
    run_to_strobe();
    tick_clk();
    tick_clk();
  endtask

  initial begin
    // Reset state
    repeat (3) tick_clk();
    chk("rst_spawn", 32'(spawn_a), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst_n_a = 1'b1; rst_n_c = 1'b1; rst_n_d = 1'b1;

    // Three idle frames without start
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_done", 32'(done_a), 32'd0);
    end
    chk("idle_pulses", 32'(pulses_a), 32'd0);

    // Basic playback, two frames per step
    start_a = 1'b1; tick_clk(); start_a = 1'b0;
    chk("run_busy", 32'(busy_a), 32'd1);
    snap = pulses_a;
    frame(); chk("t1_spawn", 32'(spawn_a), 32'd0);
    frame(); chk("t2_spawn", 32'(spawn_a), 32'h10);
    chk("t2_idx", 32'(idx_a), 32'd1);
    tick_clk(); chk("t2_width", 32'(spawn_a), 32'd0);
    frame(); chk("t3_spawn", 32'(spawn_a), 32'd0);
    frame(); chk("t4_spawn", 32'(spawn_a), 32'h03);
    chk("t4_idx", 32'(idx_a), 32'd2);
    frame(); chk("t5_done", 32'(done_a), 32'd0);
    frame(); chk("t6_done", 32'(done_a), 32'd1);
    chk("t6_busy", 32'(busy_a), 32'd0);
    chk("t6_idx", 32'(idx_a), 32'd2);
    chk("t6_spawn", 32'(spawn_a), 32'd0);
    chk("run_pulses", 32'(pulses_a - snap), 32'd2);

    // Restart from DONE with pause over ticks 2..5
    start_a = 1'b1; tick_clk(); start_a = 1'b0;
    chk("re_idx", 32'(idx_a), 32'd0);
    snap = pulses_a;
    frame();
    pause_a = 1'b1;
    for (int f = 0; f < 4; f++) frame();
    pause_a = 1'b0;
    chk("pause_nopulse", 32'(pulses_a - snap), 32'd0);
    frame(); chk("p6_spawn", 32'(spawn_a), 32'h10);
    tick_clk(); chk("p6_width", 32'(spawn_a), 32'd0);
    chk("p6_pulses", 32'(pulses_a - snap), 32'd1);

    // Reset on the cycle the next spawn is due
    frame();
    snap = pulses_a;
    run_to_strobe();
    tick_clk();
    rst_n_a = 1'b0;
    #1;
    chk("mrst_idx", 32'(idx_a), 32'd0);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    tick_clk();
    chk("mrst_spawn", 32'(spawn_a), 32'd0);
    chk("mrst_done", 32'(done_a), 32'd0);
    rst_n_a = 1'b1;
    frame();
    chk("mrst_pulses", 32'(pulses_a - snap), 32'd0);
    chk("mrst_idle", 32'(busy_a), 32'd0);

    // Start coinciding with a frame tick in IDLE: that tick is not counted
    run_to_strobe();
    tick_clk();
    start_a = 1'b1; tick_clk(); start_a = 1'b0;
    frame(); chk("sim_first", 32'(spawn_a), 32'd0);
    frame(); chk("sim_second", 32'(spawn_a), 32'h10);

    // Four-entry chart without END
    start_c = 1'b1; tick_clk(); start_c = 1'b0;
    frame(); chk("c1_spawn", 32'(spawn_c), 32'h01);
    frame(); chk("c2_spawn", 32'(spawn_c), 32'h02);
    frame(); chk("c3_spawn", 32'(spawn_c), 32'h04);
    frame(); chk("c4_spawn", 32'(spawn_c), 32'h08);
`ifdef NOTE_SEQUENCER_LOOP_EN
    chk("c4_idx", 32'(idx_c), 32'd0);
    chk("c4_done", 32'(done_c), 32'd0);
    frame(); chk("c5_spawn", 32'(spawn_c), 32'h01);
    chk("c5_idx", 32'(idx_c), 32'd1);
`else
    chk("c4_idx", 32'(idx_c), 32'd3);
    chk("c4_done", 32'(done_c), 32'd1);
    frame(); chk("c5_spawn", 32'(spawn_c), 32'd0);
    chk("c5_done", 32'(done_c), 32'd1);
`endif

    // Rest step followed by a real step and END
    start_d = 1'b1; tick_clk(); start_d = 1'b0;
    frame(); chk("d0_spawn", 32'(spawn_d), 32'd0);
    chk("d0_idx", 32'(idx_d), 32'd1);
    frame(); chk("d1_spawn", 32'(spawn_d), 32'h04);
    chk("d1_idx", 32'(idx_d), 32'd2);
    frame(); chk("d2_spawn", 32'(spawn_d), 32'd0);
`ifdef NOTE_SEQUENCER_LOOP_EN
    chk("d2_idx", 32'(idx_d), 32'd0);
    chk("d2_busy", 32'(busy_d), 32'd1);
`else
    chk("d2_idx", 32'(idx_d), 32'd2);
    chk("d2_done", 32'(done_d), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
